fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that funnels NUM_REQ requesters into one downstream FIFO write port.
// Latency: an accepted beat appears on fifo_wr_en/fifo_din exactly 1 cycle later; each new grant costs one IDLE cycle.
// Backpressure: req_ready is withheld while the tracked FIFO level equals DEPTH; the grant is held (not released) during the stall.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   req_valid/data    - per-requester valid and data (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready         - combinational per-requester accept, only the granted requester can be ready
//   fifo_rd_done      - downstream FIFO popped one entry this cycle
//   fifo_wr_en/din    - registered write strobe and {source id, data}
//   grant_id          - current or last granted requester
//   level             - tracked downstream FIFO occupancy
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 8,
  parameter int BURST_MAX  = 4,
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int LVW = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_rd_done,
  output logic                          fifo_wr_en,
  output logic [IDW+DATA_WIDTH-1:0]     fifo_din,
  output logic [IDW-1:0]                grant_id,
  output logic [LVW-1:0]                level
);

  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [IDW-1:0]              last_grant_q, last_grant_d;
  logic [IDW-1:0]              grant_id_q, grant_id_d;
  logic [BW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [LVW-1:0]              level_q, level_d;
  logic                        wr_en_q, wr_en_d;
  logic [IDW+DATA_WIDTH-1:0]   din_q, din_d;

  logic                        full;
  logic                        accept;
  logic                        rd_eff;
  logic                        gnt_valid;
  logic [DATA_WIDTH-1:0]       gnt_data;
  logic [IDW-1:0]              rr_pick;

  assign full = (level_q == LVW'(DEPTH));

  // Valid/data of the currently granted requester.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search starting after last_grant. Scanning from the far end
  // lets the nearest valid index overwrite earlier candidates.
  always_comb begin
    rr_pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        rr_pick = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == GRANT) && (grant_id_q == IDW'(i)) && !full;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_id_d   = rr_pick;
          last_grant_d = rr_pick;
          beat_cnt_d   = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (!gnt_valid) begin
          state_d = IDLE;
        end else if (!full) begin
          // Full FIFO: hold the grant and the beat count until space returns.
          accept     = 1'b1;
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q + BW'(1) == BW'(BURST_MAX)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register and occupancy tracking. A pop from an empty FIFO is ignored.
  always_comb begin
    wr_en_d = accept;
    din_d   = accept ? {grant_id_q, gnt_data} : din_q;
    rd_eff  = fifo_rd_done && (level_q != '0);
    level_d = level_q;
    case ({accept, rd_eff})
      2'b10:   level_d = level_q + LVW'(1);
      2'b01:   level_d = level_q - LVW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      level_q      <= '0;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      level_q      <= level_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign grant_id   = grant_id_q;
  assign level      = level_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change 1ns after the rising edge; registered outputs are sampled there too.
// The model tracks the owning requester, burst beats and FIFO level as plain integers.
module tb_fifo_wr_arbiter;
  localparam int DW = 8, NR = 4, DEPTH = 8, BURST = 4, IDW = 2, LVW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_rd_done;
  logic              fifo_wr_en;
  logic [IDW+DW-1:0] fifo_din;
  logic [IDW-1:0]    grant_id;
  logic [LVW-1:0]    level;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DEPTH(DEPTH), .BURST_MAX(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_rd_done(fifo_rd_done), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .grant_id(grant_id), .level(level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner = requester holding the grant (-1 when none).
  int                m_owner, m_last, m_beats, m_level, m_gid;
  bit                m_wr;
  logic [IDW+DW-1:0] m_din;

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] one;
    one = 1;
    if (m_owner >= 0 && m_level < DEPTH) return one << m_owner;
    return '0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = NR - 1; m_beats = 0; m_level = 0; m_gid = 0; m_wr = 0; m_din = '0;
  endtask

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic step();
    int nxt;
    bit acc;
    bit rd_eff;
    nxt = m_owner;
    acc = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (req_valid[idx]) begin
          nxt = idx; m_gid = idx; m_last = idx; m_beats = 0;
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      nxt = -1;
    end else if (m_level < DEPTH) begin
      acc = 1;
      m_beats++;
      if (m_beats == BURST) nxt = -1;
    end
    rd_eff = fifo_rd_done && (m_level > 0);
    m_wr = acc;
    if (acc) m_din = {m_gid[IDW-1:0], req_data[m_owner*DW +: DW]};
    m_level = m_level + int'(acc) - int'(rd_eff);
    m_owner = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_rd_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_data = 32'hA5A5_A5A5; fifo_rd_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_din !== '0) begin n_err++; $display("FAIL reset_din: got %h want 0", fifo_din); end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single();
    int idx, wcnt, cyc;
    int wcyc[6];
    do_reset();
    idx = 0; wcnt = 0; cyc = 0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h11;
    while (wcnt < 6 && cyc < 40) begin
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL single_ready: got %b want %b", req_ready, model_ready()); end
      step();
      cyc++;
      n_cmp++; if (fifo_wr_en !== m_wr) begin n_err++; $display("FAIL single_wr_en: got %b want %b", fifo_wr_en, m_wr); end
      if (fifo_wr_en) begin
        n_cmp++; if (fifo_din[7:0] !== 8'(8'h11 + wcnt)) begin n_err++; $display("FAIL single_data: got %h want %h", fifo_din[7:0], 8'(8'h11 + wcnt)); end
        wcyc[wcnt] = cyc;
        wcnt++;
      end
      if (m_wr) begin
        idx++;
        req_data[7:0] = 8'(8'h11 + idx);
        if (idx == 6) req_valid = '0;
      end
    end
    n_cmp++; if (wcnt != 6) begin n_err++; $display("FAIL single_timeout: got %0d writes want 6", wcnt); end
    else begin
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (wcyc[i] - wcyc[i-1] != ((i == 4) ? 2 : 1)) begin
          n_err++; $display("FAIL single_gap%0d: got %0d want %0d", i, wcyc[i] - wcyc[i-1], (i == 4) ? 2 : 1);
        end
      end
    end
    n_cmp++; if (level !== 4'd6) begin n_err++; $display("FAIL single_level: got %0d want 6", level); end
    n_cmp++; if (fifo_din[9:8] !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", fifo_din[9:8]); end
  endtask

  task automatic test_round_robin();
    int wcnt, cyc;
    do_reset();
    wcnt = 0; cyc = 0;
    req_valid = '1;
    req_data = $urandom;
    while (wcnt < 20 && cyc < 80) begin
      fifo_rd_done = (m_level > 0);
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL rr_ready: got %b want %b", req_ready, model_ready()); end
      step();
      cyc++;
      n_cmp++; if (fifo_wr_en !== m_wr) begin n_err++; $display("FAIL rr_wr_en: got %b want %b", fifo_wr_en, m_wr); end
      n_cmp++; if (fifo_din !== m_din) begin n_err++; $display("FAIL rr_din: got %h want %h", fifo_din, m_din); end
      if (fifo_wr_en) begin
        n_cmp++; if (fifo_din[9:8] !== 2'((wcnt / 4) % 4)) begin n_err++; $display("FAIL rr_order: got %0d want %0d", fifo_din[9:8], (wcnt / 4) % 4); end
        wcnt++;
      end
      req_data = $urandom;
    end
    n_cmp++; if (wcnt != 20) begin n_err++; $display("FAIL rr_timeout: got %0d writes want 20", wcnt); end
    fifo_rd_done = 1'b0;
  endtask

  task automatic test_full_stall();
    int wcnt;
    do_reset();
    wcnt = 0;
    req_valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      req_data = $urandom;
      step();
      if (fifo_wr_en) wcnt++;
      n_cmp++; if (level !== m_level[LVW-1:0]) begin n_err++; $display("FAIL stall_level_trk: got %0d want %0d", level, m_level); end
    end
    n_cmp++; if (wcnt != 8) begin n_err++; $display("FAIL stall_writes: got %0d want 8", wcnt); end
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL stall_level: got %0d want 8", level); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready_low: got %b want 0000", req_ready); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL stall_grant: got %0d want 2", grant_id); end
    fifo_rd_done = 1'b1;
    step();
    fifo_rd_done = 1'b0;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_ready_resume: got %b want 0100", req_ready); end
    wcnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (fifo_wr_en) wcnt++;
    end
    n_cmp++; if (wcnt != 1) begin n_err++; $display("FAIL stall_one_more: got %0d want 1", wcnt); end
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL stall_refill: got %0d want 8", level); end
  endtask

  task automatic test_simultaneous();
    bit done;
    do_reset();
    done = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 40 && !done; c++) begin
      req_data = $urandom;
      if (m_level == 5 && model_ready()[0]) begin
        fifo_rd_done = 1'b1;
        step();
        fifo_rd_done = 1'b0;
        done = 1;
      end else begin
        step();
      end
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL simul_timeout: got 0 want 1"); end
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL simul_wr_en: got %b want 1", fifo_wr_en); end
    n_cmp++; if (level !== 4'd5) begin n_err++; $display("FAIL simul_level5: got %0d want 5", level); end
    do_reset();
    fifo_rd_done = 1'b1;
    step();
    fifo_rd_done = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL simul_level0: got %0d want 0", level); end
  endtask

  task automatic test_early_release();
    int wcnt, cyc;
    do_reset();
    wcnt = 0; cyc = 0;
    req_valid = 4'b1010;
    while (wcnt < 2 && cyc < 20) begin
      req_data = $urandom;
      step();
      cyc++;
      if (fifo_wr_en) begin
        n_cmp++; if (fifo_din[9:8] !== 2'd1) begin n_err++; $display("FAIL early_id: got %0d want 1", fifo_din[9:8]); end
        wcnt++;
      end
    end
    n_cmp++; if (wcnt != 2) begin n_err++; $display("FAIL early_timeout: got %0d writes want 2", wcnt); end
    req_valid = 4'b1000;
    step();
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL early_no_beat: got %b want 0", fifo_wr_en); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL early_idle: got %b want 0000", req_ready); end
    step();
    n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL early_grant3: got %0d want 3", grant_id); end
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL early_ready3: got %b want 1000", req_ready); end
  endtask

  task automatic test_reset_mid();
    int wcnt, cyc;
    do_reset();
    wcnt = 0; cyc = 0;
    req_valid = 4'b0001;
    while (wcnt < 2 && cyc < 20) begin
      req_data = $urandom;
      step();
      cyc++;
      if (fifo_wr_en) wcnt++;
    end
    n_cmp++; if (wcnt != 2) begin n_err++; $display("FAIL rstmid_timeout: got %0d writes want 2", wcnt); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL rstmid_level: got %0d want 0", level); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready: got %b want 0000", req_ready); end
    req_valid = 4'b1111;
    @(posedge clk);
    #1;
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_discard: got %b want 0", fifo_wr_en); end
    rst = 1'b0;
    step();
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rstmid_grant0: got %0d want 0", grant_id); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_ready0: got %b want 0001", req_ready); end
  endtask

  task automatic test_random();
    do_reset();
    req_valid = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
      req_data = $urandom;
      fifo_rd_done = (m_level > 0) && ($urandom_range(0, 2) == 0);
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL rand_ready: got %b want %b", req_ready, model_ready()); end
      step();
      n_cmp++; if (fifo_wr_en !== m_wr) begin n_err++; $display("FAIL rand_wr_en: got %b want %b", fifo_wr_en, m_wr); end
      n_cmp++; if (fifo_din !== m_din) begin n_err++; $display("FAIL rand_din: got %h want %h", fifo_din, m_din); end
      n_cmp++; if (grant_id !== m_gid[IDW-1:0]) begin n_err++; $display("FAIL rand_grant: got %0d want %0d", grant_id, m_gid); end
      n_cmp++; if (level !== m_level[LVW-1:0]) begin n_err++; $display("FAIL rand_level: got %0d want %0d", level, m_level); end
    end
    fifo_rd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_rd_done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_simultaneous();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
